// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit index width; a single-digit operand still needs a 1-bit index.
    function automatic int idx_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit magnitude slice: the first differing bit from the
// MSB end decides gt/lt, and the running equality chain gates lower bits.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic eq_chain;

    always_comb begin
        eq_chain = 1'b1;
        gt       = 1'b0;
        lt       = 1'b0;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt       = gt | (eq_chain &  a[i] & ~b[i]);
            lt       = lt | (eq_chain & ~a[i] &  b[i]);
            eq_chain = eq_chain & ~(a[i] ^ b[i]);
        end
        eq = eq_chain;
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with early exit and valid/ready
// handshakes. Define CMP_SIGNED_EN to add the is_signed port (two's complement).
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_greater,
    output logic             a_less,
    output logic             a_equal_b
);

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int IDX_W      = idx_width(WIDTH, DIGIT);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NUM_DIGITS - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT and DIGIT in [1, WIDTH]");
    end

    cmp_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             gt_r, lt_r, eq_r;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_gt, dig_lt, dig_eq;
    logic             accept, last_digit;

    assign accept     = (state == IDLE) && in_valid;
    assign last_digit = (idx == '0);

`ifdef CMP_SIGNED_EN
    localparam logic [DIGIT-1:0] SIGN_MASK = DIGIT'(1) << (DIGIT - 1);
    logic signed_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_r <= 1'b0;
        end else if (accept) begin
            signed_r <= is_signed;
        end
    end
`endif

    // Digit select; in signed mode the operand sign bits are flipped on the MSB
    // digit only, turning two's complement into offset binary.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_dig = a_r[i*DIGIT +: DIGIT];
                b_dig = b_r[i*DIGIT +: DIGIT];
            end
        end
`ifdef CMP_SIGNED_EN
        if (signed_r && (idx == IDX_MSB)) begin
            a_dig = a_dig ^ SIGN_MASK;
            b_dig = b_dig ^ SIGN_MASK;
        end
`endif
    end

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_dig),
        .b  (b_dig),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)                 state_nxt = SCAN;
            SCAN: if (!dig_eq || last_digit)    state_nxt = DONE;
            DONE: if (out_ready)                state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            eq_r <= 1'b0;
        end else if (accept) begin
            idx  <= IDX_MSB;
            a_r  <= a;
            b_r  <= b;
        end else if (state == SCAN) begin
            if (!dig_eq) begin
                gt_r <= dig_gt;
                lt_r <= dig_lt;
                eq_r <= 1'b0;
            end else if (last_digit) begin
                gt_r <= 1'b0;
                lt_r <= 1'b0;
                eq_r <= 1'b1;
            end else begin
                idx  <= idx - 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign a_greater = out_valid & gt_r;
    assign a_less    = out_valid & lt_r;
    assign a_equal_b = out_valid & eq_r;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int ND    = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in, b_in;
    logic             sgn_in;
    logic             out_valid;
    logic             out_ready;
    logic             a_greater, a_less, a_equal_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
`ifdef CMP_SIGNED_EN
        .is_signed (sgn_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_greater (a_greater),
        .a_less    (a_less),
        .a_equal_b (a_equal_b)
    );

    // Reference: plain arithmetic compare; latency is the position (from the
    // MSB end) of the first differing digit, or all digits when equal.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s, output logic [2:0] exp_f, output int exp_lat);
        logic [WIDTH-1:0] diff;
        bit found;
        if (s) exp_f = {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
        else   exp_f = {a > b, a < b, a == b};
        diff    = a ^ b;
        exp_lat = ND;
        found   = 0;
        for (int k = 1; k <= ND; k++) begin
            if (!found && (((diff >> ((ND - k) * DIGIT)) & WIDTH'(4'hF)) != '0)) begin
                exp_lat = k;
                found   = 1;
            end
        end
    endfunction

    // Starts one compare (called just after a rising edge, block idle) and
    // waits for out_valid; leaves the block holding its result.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                           output logic [2:0] got_f, output int lat, output bit timed_out,
                           output bit leak);
        in_valid = 1'b1; a_in = a; b_in = b; sgn_in = s;
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); sgn_in = ~s;
        lat = 0; timed_out = 0; leak = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (a_greater | a_less | a_equal_b) leak = 1;
            if (lat > 20) begin timed_out = 1; break; end
        end
        got_f = {a_greater, a_less, a_equal_b};
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; sgn_in = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({a_greater, a_less, a_equal_b} !== 3'b000)
            begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_greater, a_less, a_equal_b}); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4] = '{16'h1234, 16'h8000, 16'h12A4, 16'h0001};
        logic [WIDTH-1:0] vb [4] = '{16'h1234, 16'h7FFF, 16'h12B4, 16'h0000};
        logic [2:0]       vf [4] = '{3'b001, 3'b100, 3'b010, 3'b100};
        int               vl [4] = '{4, 1, 3, 4};
        logic [2:0] got; int lat; bit to, leak;
        for (int i = 0; i < 4; i++) begin
            run_cmp(va[i], vb[i], 1'b0, got, lat, to, leak);
            checks++;
            if (to || got !== vf[i] || lat != vl[i] || leak) begin
                failures++;
                $display("FAIL directed_%0d a=%h b=%h got flags=%b lat=%0d timeout=%0d leak=%0d exp flags=%b lat=%0d",
                         i, va[i], vb[i], got, lat, to, leak, vf[i], vl[i]);
            end
            release_out();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                begin failures++; $display("FAIL directed_release_%0d in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid); end
        end
    endtask

`ifdef CMP_SIGNED_EN
    task automatic test_signed();
        logic [2:0] got, exp_f; int lat, exp_lat; bit to, leak;
        logic [WIDTH-1:0] a, b;
        run_cmp(16'h8000, 16'h7FFF, 1'b1, got, lat, to, leak);
        checks++;
        if (to || got !== 3'b010 || lat != 1)
            begin failures++; $display("FAIL signed_8000_7fff got flags=%b lat=%0d exp flags=010 lat=1", got, lat); end
        release_out();
        for (int i = 0; i < 20; i++) begin
            a = WIDTH'($urandom);
            b = (i % 2) ? (a ^ WIDTH'($urandom_range(1, 255))) : WIDTH'($urandom);
            model(a, b, 1'b1, exp_f, exp_lat);
            run_cmp(a, b, 1'b1, got, lat, to, leak);
            checks++;
            if (to || got !== exp_f || lat != exp_lat)
                begin failures++; $display("FAIL signed_rand a=%h b=%h got flags=%b lat=%0d exp flags=%b lat=%0d", a, b, got, lat, exp_f, exp_lat); end
            release_out();
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0] got, exp_f; int lat, exp_lat; bit to, leak;
        logic [WIDTH-1:0] a, b;
        logic s;
        for (int i = 0; i < 60; i++) begin
            a = WIDTH'($urandom);
            case (i % 4)
                0: b = WIDTH'($urandom);
                1: b = a ^ WIDTH'($urandom_range(0, 15));
                2: b = a ^ WIDTH'($urandom_range(0, 255));
                default: b = a;
            endcase
`ifdef CMP_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            model(a, b, s, exp_f, exp_lat);
            run_cmp(a, b, s, got, lat, to, leak);
            checks++;
            if (to || got !== exp_f || lat != exp_lat || leak)
                begin failures++; $display("FAIL random a=%h b=%h s=%b got flags=%b lat=%0d leak=%0d exp flags=%b lat=%0d", a, b, s, got, lat, leak, exp_f, exp_lat); end
            release_out();
        end
    endtask

    task automatic test_hold();
        logic [2:0] got; int lat; bit to, leak;
        bit bad;
        run_cmp(16'h00F0, 16'h00E0, 1'b0, got, lat, to, leak);
        checks++;
        if (to || got !== 3'b100 || lat != 3)
            begin failures++; $display("FAIL hold_result got flags=%b lat=%0d exp flags=100 lat=3", got, lat); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {a_greater, a_less, a_equal_b} !== 3'b100) bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin failures++; $display("FAIL hold_stable out_valid=%b in_ready=%b flags=%b exp 1/0/100", out_valid, in_ready, {a_greater, a_less, a_equal_b}); end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {a_greater, a_less, a_equal_b} !== 3'b000)
            begin failures++; $display("FAIL hold_release in_ready=%b out_valid=%b flags=%b exp 1/0/000", in_ready, out_valid, {a_greater, a_less, a_equal_b}); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp_f; int lat, exp_lat; bit to, leak;
        logic [WIDTH-1:0] c, d;
        run_cmp(16'h5000, 16'h6000, 1'b0, got, lat, to, leak);
        c = 16'h3C3C; d = 16'h3C5C;
        model(c, d, 1'b0, exp_f, exp_lat);
        in_valid = 1'b1; a_in = c; b_in = d; sgn_in = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL b2b_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_capture in_ready=%b exp 0", in_ready); end
        lat = 0; to = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (lat > 20) begin to = 1; break; end
        end
        got = {a_greater, a_less, a_equal_b};
        checks++;
        if (to || got !== exp_f || lat != exp_lat)
            begin failures++; $display("FAIL b2b_result got flags=%b lat=%0d exp flags=%b lat=%0d", got, lat, exp_f, exp_lat); end
        release_out();
    endtask

    task automatic test_reset_mid_scan();
        logic [2:0] got; int lat; bit to, leak;
        in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h1234; sgn_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL midscan_busy in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {a_greater, a_less, a_equal_b} !== 3'b000)
            begin failures++; $display("FAIL midscan_reset in_ready=%b out_valid=%b flags=%b exp 1/0/000", in_ready, out_valid, {a_greater, a_less, a_equal_b}); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmp(16'h0F00, 16'h0F01, 1'b0, got, lat, to, leak);
        checks++;
        if (to || got !== 3'b010 || lat != 4)
            begin failures++; $display("FAIL midscan_fresh got flags=%b lat=%0d exp flags=010 lat=4", got, lat); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef CMP_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
